// File: rtl/sim_cosim_checker.sv
// Multi-hart lockstep checker for co-simulation.
// Each hart owns a small FIFO of expected retirements (pc, insn) fed from the
// shared reference port. Every DUT retirement strobe is compared against the
// FIFO head, and the result is reported as registered match/miss pulses, the
// expected record, sticky underflow, a saturating miss counter and a global
// sticky fatal flag.
module sim_cosim_checker #(
  parameter int NHART      = 2,
  parameter int XLEN       = 64,
  parameter int ILEN       = 32,
  parameter int DEPTH      = 4,
  parameter int MISS_LIMIT = 8,
  parameter int HW         = (NHART > 1) ? $clog2(NHART) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  resync,
  input  logic                                  ref_valid,
  output logic                                  ref_ready,
  input  logic [HW-1:0]                         ref_hart,
  input  logic [XLEN-1:0]                       ref_pc,
  input  logic [ILEN-1:0]                       ref_insn,
  input  logic [NHART-1:0]                      dut_valid,
  input  logic [NHART*XLEN-1:0]                 dut_pc,
  output logic [NHART*XLEN-1:0]                 exp_pc,
  output logic [NHART*ILEN-1:0]                 exp_insn,
  output logic [NHART-1:0]                      match,
  output logic [NHART-1:0]                      miss,
  output logic [NHART-1:0]                      underflow,
  output logic [NHART*16-1:0]                   miss_cnt,
  output logic                                  fatal,
  output logic [NHART*($clog2(DEPTH)+1)-1:0]    level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int RW = XLEN + ILEN;

  logic [NHART-1:0] full_w;
  logic [NHART-1:0] reach_w;
  logic             fatal_q;

  // Shared reference port: ready only for an existing hart whose FIFO has room.
  // Out-of-range hart indices never match a channel, so they stay not-ready.
  always_comb begin
    ref_ready = 1'b0;
    for (int h = 0; h < NHART; h++) begin
      if (ref_hart == HW'(h)) begin
        ref_ready = ~full_w[h];
      end
    end
  end

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    logic [RW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [LW-1:0]   cnt_q;
    logic [LW-1:0]   cnt_d;
    logic [XLEN-1:0] exp_pc_q;
    logic [ILEN-1:0] exp_insn_q;
    logic            match_q;
    logic            miss_q;
    logic            uf_q;
    logic [15:0]     mcnt_q;

    logic            push_w;
    logic            pop_w;
    logic            empty_w;
    logic            chk_w;
    logic            hit_w;
    logic            miss_ev_w;
    logic [RW-1:0]   head_w;
    logic [XLEN-1:0] head_pc_w;
    logic [ILEN-1:0] head_insn_w;
    logic [XLEN-1:0] dpc_w;

    assign dpc_w       = dut_pc[h*XLEN +: XLEN];
    assign empty_w     = (cnt_q == '0);
    assign full_w[h]   = (cnt_q == LW'(DEPTH));
    // ref_ready already folds in ~full, so a full FIFO never takes a push
    // even when it pops in the same cycle.
    assign push_w      = ref_valid & ref_ready & (ref_hart == HW'(h));
    assign head_w      = mem_q[rd_ptr_q];
    assign head_pc_w   = head_w[RW-1 -: XLEN];
    assign head_insn_w = head_w[ILEN-1:0];
    assign hit_w       = (head_pc_w == dpc_w);
    // A check against a real head; an empty FIFO is an underflow instead.
    assign chk_w       = dut_valid[h] & ~empty_w;
    // Strict mode retries a mismatching head, resync mode skips it.
    assign pop_w       = chk_w & (hit_w | resync);
    assign miss_ev_w   = dut_valid[h] & ~(chk_w & hit_w);
    assign cnt_d       = cnt_q + LW'(push_w) - LW'(pop_w);

    // Record storage: data only, no reset needed since occupancy guards reads.
    always_ff @(posedge clk) begin
      if (push_w) begin
        mem_q[wr_ptr_q] <= {ref_pc, ref_insn};
      end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push_w) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop_w)  rd_ptr_q <= rd_ptr_q + PW'(1);
        cnt_q <= cnt_d;
      end
    end

    // Registered check results, expected record and saturating miss count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        match_q    <= 1'b0;
        miss_q     <= 1'b0;
        uf_q       <= 1'b0;
        exp_pc_q   <= '0;
        exp_insn_q <= '0;
        mcnt_q     <= '0;
      end else begin
        match_q <= chk_w & hit_w;
        miss_q  <= miss_ev_w;
        if (dut_valid[h] && empty_w) begin
          uf_q <= 1'b1;
        end
        if (chk_w) begin
          exp_pc_q   <= head_pc_w;
          exp_insn_q <= head_insn_w;
        end
        if (miss_ev_w && (mcnt_q != 16'hFFFF)) begin
          mcnt_q <= mcnt_q + 16'd1;
        end
      end
    end

    assign reach_w[h] = (MISS_LIMIT > 0) && (mcnt_q >= 16'(MISS_LIMIT));

    assign match[h]                   = match_q;
    assign miss[h]                    = miss_q;
    assign underflow[h]               = uf_q;
    assign exp_pc[h*XLEN +: XLEN]     = exp_pc_q;
    assign exp_insn[h*ILEN +: ILEN]   = exp_insn_q;
    assign miss_cnt[h*16 +: 16]       = mcnt_q;
    assign level[h*LW +: LW]          = cnt_q;
  end

  // Fatal latches one cycle after any hart's counter reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fatal_q <= 1'b0;
    end else if (|reach_w) begin
      fatal_q <= 1'b1;
    end
  end

  assign fatal = fatal_q;

endmodule

// File: tb/tb_sim_cosim_checker.sv
// Self-checking bench for sim_cosim_checker: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based reference model.
module tb_sim_cosim_checker;
  localparam int NH = 2;
  localparam int XL = 64;
  localparam int IL = 32;
  localparam int DP = 4;
  localparam int ML = 8;
  localparam int LW = $clog2(DP) + 1;

  typedef logic [XL+IL-1:0] rec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             resync;
  logic             ref_valid;
  logic             ref_ready;
  logic [0:0]       ref_hart;
  logic [XL-1:0]    ref_pc;
  logic [IL-1:0]    ref_insn;
  logic [NH-1:0]    dut_valid;
  logic [NH*XL-1:0] dut_pc;
  logic [NH*XL-1:0] exp_pc;
  logic [NH*IL-1:0] exp_insn;
  logic [NH-1:0]    match;
  logic [NH-1:0]    miss;
  logic [NH-1:0]    underflow;
  logic [NH*16-1:0] miss_cnt;
  logic             fatal;
  logic [NH*LW-1:0] level;

  int checks   = 0;
  int failures = 0;

  sim_cosim_checker #(.NHART(NH), .XLEN(XL), .ILEN(IL), .DEPTH(DP), .MISS_LIMIT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .resync(resync),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_hart(ref_hart),
    .ref_pc(ref_pc), .ref_insn(ref_insn),
    .dut_valid(dut_valid), .dut_pc(dut_pc),
    .exp_pc(exp_pc), .exp_insn(exp_insn), .match(match), .miss(miss),
    .underflow(underflow), .miss_cnt(miss_cnt), .fatal(fatal), .level(level)
  );

  always #5 clk = ~clk;

  // Reference model state
  rec_t          mq [NH][$];
  logic [NH-1:0] m_match = '0;
  logic [NH-1:0] m_miss  = '0;
  logic [NH-1:0] m_uf    = '0;
  logic [XL-1:0] m_epc   [NH];
  logic [IL-1:0] m_einsn [NH];
  int            m_cnt   [NH];
  logic          m_fatal = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return (int'(ref_hart) < NH) && (mq[ref_hart].size() < DP);
  endfunction

  // Model: decisions from pre-edge queue contents, then the accepted push.
  always @(posedge clk or negedge rst_n) begin : model
    bit   acc;
    rec_t hd;
    logic [XL-1:0] pc;
    if (!rst_n) begin
      for (int h = 0; h < NH; h++) begin
        mq[h].delete();
        m_epc[h] = '0; m_einsn[h] = '0; m_cnt[h] = 0;
      end
      m_match = '0; m_miss = '0; m_uf = '0; m_fatal = 1'b0;
    end else begin
      acc = ref_valid && model_ready();
      for (int h = 0; h < NH; h++)
        if (ML > 0 && m_cnt[h] >= ML) m_fatal = 1'b1;
      for (int h = 0; h < NH; h++) begin
        m_match[h] = 1'b0;
        m_miss[h]  = 1'b0;
        if (dut_valid[h]) begin
          pc = dut_pc[h*XL +: XL];
          if (mq[h].size() == 0) begin
            m_miss[h] = 1'b1;
            m_uf[h]   = 1'b1;
            if (m_cnt[h] < 65535) m_cnt[h]++;
          end else begin
            hd = mq[h][0];
            m_epc[h]   = hd[XL+IL-1:IL];
            m_einsn[h] = hd[IL-1:0];
            if (hd[XL+IL-1:IL] == pc) begin
              m_match[h] = 1'b1;
              void'(mq[h].pop_front());
            end else begin
              m_miss[h] = 1'b1;
              if (m_cnt[h] < 65535) m_cnt[h]++;
              if (resync) void'(mq[h].pop_front());
            end
          end
        end
      end
      if (acc) mq[ref_hart].push_back({ref_pc, ref_insn});
    end
  end

  // Compare process: every output, every cycle, on the inactive edge.
  always @(negedge clk) begin
    chk("ref_ready", 64'(ref_ready), 64'(model_ready()));
    chk("match", 64'(match), 64'(m_match));
    chk("miss", 64'(miss), 64'(m_miss));
    chk("underflow", 64'(underflow), 64'(m_uf));
    chk("fatal", 64'(fatal), 64'(m_fatal));
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("exp_pc[%0d]", h), exp_pc[h*XL +: XL], m_epc[h]);
      chk($sformatf("exp_insn[%0d]", h), 64'(exp_insn[h*IL +: IL]), 64'(m_einsn[h]));
      chk($sformatf("miss_cnt[%0d]", h), 64'(miss_cnt[h*16 +: 16]), 64'(m_cnt[h]));
      chk($sformatf("level[%0d]", h), 64'(level[h*LW +: LW]), 64'(mq[h].size()));
    end
  end

  task automatic drive(input bit rv, input bit rh, input logic [63:0] rp, input logic [31:0] ri,
                       input bit [1:0] dv, input logic [63:0] p0, input logic [63:0] p1);
    ref_valid = rv; ref_hart = rh; ref_pc = rp; ref_insn = ri;
    dut_valid = dv; dut_pc = {p1, p0};
    @(posedge clk); #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  function automatic logic [63:0] pick_pc(input int h);
    rec_t hd;
    if (mq[h].size() > 0 && $urandom_range(0, 9) < 6) begin
      hd = mq[h][0];
      return hd[XL+IL-1:IL];
    end
    return 64'h100 + 64'(4 * $urandom_range(0, 3));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; resync = 1'b0;
    ref_valid = 0; ref_hart = 0; ref_pc = 0; ref_insn = 0; dut_valid = 0; dut_pc = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst level", 64'(level), 64'd0);
    chk("rst match/miss", 64'({match, miss}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Two matching retirements on hart 0
    drive(1, 0, 64'h1000, 32'h13, 2'b00, 0, 0);
    drive(1, 0, 64'h1004, 32'h00000013, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b01, 64'h1000, 0);
    chk("t1 match0 a", 64'(match[0]), 64'd1);
    drive(0, 0, 0, 0, 2'b01, 64'h1004, 0);
    chk("t1 match0 b", 64'(match[0]), 64'd1);
    idle();
    chk("t1 exp_pc0", exp_pc[63:0], 64'h1004);
    chk("t1 level0", 64'(level[LW-1:0]), 64'd0);
    chk("t1 miss_cnt0", 64'(miss_cnt[15:0]), 64'd0);

    // Fill hart 1, observe backpressure and push-after-pop
    for (int i = 0; i < DP; i++) drive(1, 1, 64'h5000 + 64'(4 * i), 32'(i), 2'b00, 0, 0);
    ref_valid = 1; ref_hart = 1; ref_pc = 64'h5010; ref_insn = 32'h44; dut_valid = 0;
    #1 chk("t2 ready hart1 full", 64'(ref_ready), 64'd0);
    ref_hart = 0;
    #1 chk("t2 ready hart0", 64'(ref_ready), 64'd1);
    drive(1, 1, 64'h5010, 32'h44, 2'b00, 0, 0);
    chk("t2 level1 held", 64'(level[2*LW-1:LW]), 64'd4);
    drive(1, 1, 64'h5010, 32'h44, 2'b10, 0, 64'h5000);
    chk("t2 level1 after pop", 64'(level[2*LW-1:LW]), 64'd3);
    chk("t2 match1", 64'(match[1]), 64'd1);
    drive(1, 1, 64'h5010, 32'h44, 2'b00, 0, 0);
    chk("t2 level1 refill", 64'(level[2*LW-1:LW]), 64'd4);
    for (int i = 1; i <= DP; i++) drive(0, 0, 0, 0, 2'b10, 0, 64'h5000 + 64'(4 * i));
    chk("t2 exp_pc1", exp_pc[127:64], 64'h5010);
    chk("t2 exp_insn1", 64'(exp_insn[63:32]), 64'h44);
    chk("t2 level1 drained", 64'(level[2*LW-1:LW]), 64'd0);

    // Strict mode retry
    resync = 0;
    drive(1, 0, 64'h2000, 32'hAA, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b01, 64'h2008, 0);
    chk("t3 miss0 a", 64'(miss[0]), 64'd1);
    drive(0, 0, 0, 0, 2'b01, 64'h2008, 0);
    chk("t3 miss0 b", 64'(miss[0]), 64'd1);
    chk("t3 miss_cnt0", 64'(miss_cnt[15:0]), 64'd2);
    chk("t3 level0", 64'(level[LW-1:0]), 64'd1);
    chk("t3 exp_pc0", exp_pc[63:0], 64'h2000);
    drive(0, 0, 0, 0, 2'b01, 64'h2000, 0);
    chk("t3 match0", 64'(match[0]), 64'd1);

    // Resync mode skip
    resync = 1;
    drive(1, 0, 64'h3000, 32'hB0, 2'b00, 0, 0);
    drive(1, 0, 64'h3004, 32'hB4, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b01, 64'h3004, 0);
    chk("t4 miss0", 64'(miss[0]), 64'd1);
    chk("t4 level0", 64'(level[LW-1:0]), 64'd1);
    drive(0, 0, 0, 0, 2'b01, 64'h3004, 0);
    chk("t4 match0", 64'(match[0]), 64'd1);
    chk("t4 level0 empty", 64'(level[LW-1:0]), 64'd0);
    chk("t4 exp_insn0", 64'(exp_insn[31:0]), 64'hB4);

    // Underflow and fatal (3 misses so far, 5 underflows reach 8)
    resync = 0;
    drive(0, 0, 0, 0, 2'b01, 64'h7777, 0);
    chk("t5 miss0", 64'(miss[0]), 64'd1);
    chk("t5 underflow0", 64'(underflow[0]), 64'd1);
    chk("t5 exp_pc0 kept", exp_pc[63:0], 64'h3004);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 2'b01, 64'h7777, 0);
    chk("t5 miss_cnt0", 64'(miss_cnt[15:0]), 64'd8);
    chk("t5 fatal not yet", 64'(fatal), 64'd0);
    idle();
    chk("t5 fatal", 64'(fatal), 64'd1);
    chk("t5 underflow sticky", 64'(underflow[0]), 64'd1);

    // Randomized traffic with an asynchronous reset in the middle
    for (int c = 0; c < 300; c++) begin
      logic [63:0] p0, p1;
      if ($urandom_range(0, 15) == 0) resync = 1'($urandom_range(0, 1));
      p0 = pick_pc(0);
      p1 = pick_pc(1);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            64'h100 + 64'(4 * $urandom_range(0, 3)), 32'($urandom),
            2'($urandom_range(0, 3)), p0, p1);
      if (c == 150) begin
        rst_n = 1'b0;
        #1;
        chk("rst2 level", 64'(level), 64'd0);
        chk("rst2 miss_cnt", 64'(miss_cnt), 64'd0);
        chk("rst2 flags", 64'({fatal, underflow, match, miss}), 64'd0);
        chk("rst2 exp_pc", exp_pc[63:0] | exp_pc[127:64], 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
      end
    end
    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
